// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the sequential MixColumns block
package aes_pkg;

  localparam int         COL_W        = 32;
  localparam int         NUM_COLS     = 4;
  localparam logic [7:0] AES_POLY_LOW = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/aes_mixcol_column.sv
// rtl/aes_mixcol_column.sv - combinational one-column MixColumns; inverse under AES_INV_MIXCOL_EN
module aes_mixcol_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
`ifdef AES_INV_MIXCOL_EN
  input  logic             inv_i,
`endif
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a  [NUM_COLS];
  logic [7:0] x2 [NUM_COLS];
  logic [7:0] fwd[NUM_COLS];

  for (genvar r = 0; r < NUM_COLS; r++) begin : g_row
    localparam int R1 = (r + 1) % NUM_COLS;
    localparam int R2 = (r + 2) % NUM_COLS;
    localparam int R3 = (r + 3) % NUM_COLS;

    assign a[r] = col_i[COL_W-1-8*r -: 8];

    aes_xtime u_x2 (.a_i(a[r]), .y_o(x2[r]));

    // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
    assign fwd[r] = x2[r] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3];
  end

`ifdef AES_INV_MIXCOL_EN
  logic [7:0] x4 [NUM_COLS];
  logic [7:0] x8 [NUM_COLS];
  logic [7:0] inv[NUM_COLS];

  for (genvar r = 0; r < NUM_COLS; r++) begin : g_inv
    localparam int R1 = (r + 1) % NUM_COLS;
    localparam int R2 = (r + 2) % NUM_COLS;
    localparam int R3 = (r + 3) % NUM_COLS;

    aes_xtime u_x4 (.a_i(x2[r]), .y_o(x4[r]));
    aes_xtime u_x8 (.a_i(x4[r]), .y_o(x8[r]));

    // 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3]
    assign inv[r] = (x8[r]  ^ x4[r]  ^ x2[r])
                  ^ (x8[R1] ^ x2[R1] ^ a[R1])
                  ^ (x8[R2] ^ x4[R2] ^ a[R2])
                  ^ (x8[R3] ^ a[R3]);

    assign col_o[COL_W-1-8*r -: 8] = inv_i ? inv[r] : fwd[r];
  end
`else
  for (genvar r = 0; r < NUM_COLS; r++) begin : g_out
    assign col_o[COL_W-1-8*r -: 8] = fwd[r];
  end
`endif

endmodule

// File: rtl/aes_xtime.sv
// rtl/aes_xtime.sv - GF(2^8) multiply-by-two modulo x^8+x^4+x^3+x+1
module aes_xtime
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? AES_POLY_LOW : 8'h00);

endmodule

// File: rtl/aes_mixcol_seq.sv
// rtl/aes_mixcol_seq.sv - sequential MixColumns, NUM_COL_UNITS columns/cycle; AES_INV_MIXCOL_EN adds in_inv
module aes_mixcol_seq
  import aes_pkg::*;
#(
  parameter int NUM_COL_UNITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] in_state,
`ifdef AES_INV_MIXCOL_EN
  input  logic                      in_inv,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] out_state,
  output logic                      busy
);

  localparam logic [1:0] COL_STEP  = 2'(NUM_COL_UNITS);
  localparam logic [1:0] LAST_BASE = 2'(NUM_COLS - NUM_COL_UNITS);

  state_e                      fsm_q;
  logic [1:0]                  col_q;
  logic [NUM_COLS*COL_W-1:0]   work_q;
  logic [NUM_COLS*COL_W-1:0]   work_d;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic                        busy_q;
`ifdef AES_INV_MIXCOL_EN
  logic                        inv_q;
`endif

  logic [COL_W-1:0] cols     [NUM_COLS];
  logic [COL_W-1:0] cols_d   [NUM_COLS];
  logic [COL_W-1:0] unit_in  [NUM_COL_UNITS];
  logic [COL_W-1:0] unit_out [NUM_COL_UNITS];

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_cols
    assign cols[c]                          = work_q[NUM_COLS*COL_W-1-COL_W*c -: COL_W];
    assign work_d[NUM_COLS*COL_W-1-COL_W*c -: COL_W] = cols_d[c];
  end

  // Units always work on the aligned group starting at col_q
  for (genvar u = 0; u < NUM_COL_UNITS; u++) begin : g_unit
    assign unit_in[u] = cols[col_q + 2'(u)];

    aes_mixcol_column u_col (
      .col_i (unit_in[u]),
`ifdef AES_INV_MIXCOL_EN
      .inv_i (inv_q),
`endif
      .col_o (unit_out[u])
    );
  end

  always_comb begin
    cols_d = cols;
    for (int u = 0; u < NUM_COL_UNITS; u++) begin
      cols_d[col_q + 2'(u)] = unit_out[u];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AES_INV_MIXCOL_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= in_state;
            col_q      <= 2'd0;
`ifdef AES_INV_MIXCOL_EN
            inv_q      <= in_inv;
`endif
            fsm_q      <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          work_q <= work_d;
          col_q  <= col_q + COL_STEP;
          if (col_q == LAST_BASE) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          col_q       <= 2'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// tb/tb_aes_mixcol_seq.sv - directed bench for aes_mixcol_seq at N=1,2,4; inverse tests under AES_INV_MIXCOL_EN
module tb_aes_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
`ifdef AES_INV_MIXCOL_EN
  logic         in_inv;
`endif

  logic         rdy [3];
  logic         ov  [3];
  logic         bsy [3];
  logic [127:0] os  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_mixcol_seq #(.NUM_COL_UNITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_state(in_state),
`ifdef AES_INV_MIXCOL_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bsy[0]));

  aes_mixcol_seq #(.NUM_COL_UNITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_state(in_state),
`ifdef AES_INV_MIXCOL_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bsy[1]));

  aes_mixcol_seq #(.NUM_COL_UNITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_state(in_state),
`ifdef AES_INV_MIXCOL_EN
    .in_inv(in_inv),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bsy[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int i);
    return 4 >> i;
  endfunction

  task automatic idle_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rdy%0d", tag, i), 128'(rdy[i]), 128'd1);
      chk($sformatf("%s_ov%0d", tag, i), 128'(ov[i]), 128'd0);
      chk($sformatf("%s_busy%0d", tag, i), 128'(bsy[i]), 128'd0);
    end
  endtask

  // Accept on all three DUTs, watch latency and a long stall, then hand off
  task automatic run_all(input string tag, input logic [127:0] st, input logic [127:0] exp,
                         input bit junk);
    in_state = st;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (junk) begin
      in_valid = 1'b1;
      in_state = ~st;
    end
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s_ov%0d_k%0d", tag, i, k), 128'(ov[i]), 128'(k >= lat(i)));
        if (k >= lat(i))
          chk($sformatf("%s_os%0d_k%0d", tag, i, k), os[i], exp);
      end
      if (junk) begin
        chk($sformatf("%s_rdy0_k%0d", tag, k), 128'(rdy[0]), 128'd0);
        chk($sformatf("%s_busy0_k%0d", tag, k), 128'(bsy[0]), 128'd1);
      end
    end
    in_valid  = 1'b0;
    in_state  = st;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    idle_all({tag, "_after"});
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
`ifdef AES_INV_MIXCOL_EN
    in_inv    = 1'b0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    idle_all("rst_hold");
    for (int i = 0; i < 3; i++) chk($sformatf("rst_os%0d", i), os[i], 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    idle_all("rst_rel");
    for (int i = 0; i < 3; i++) chk($sformatf("rel_os%0d", i), os[i], 128'h0);

    run_all("db13", {4{32'hdb135345}}, {4{32'h8e4da1bc}}, 1'b0);

    run_all("mix", {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5},
            {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 1'b1);

    // Abort mid-CALC on the N=1 instance
    in_state = {4{32'hdb135345}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_ov0_k%0d", k), 128'(ov[0]), 128'd0);
    end
    rst = 1'b1;
    #1;
    chk("abort_os0_async", os[0], 128'h0);
    chk("abort_ov0_async", 128'(ov[0]), 128'd0);
    @(posedge clk); #1;
    chk("abort_ov0_hold", 128'(ov[0]), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    idle_all("abort_rel");
    chk("abort_os0_rel", os[0], 128'h0);

    run_all("2d26", {4{32'h2d26314c}}, {4{32'h4d7ebdf8}}, 1'b0);

    // Back-to-back on N=1: accept at k=0, done k=4, handoff k=5, accept k=6, done k=10
    in_state  = {4{32'h2d26314c}};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ov0_k%0d", k), 128'(ov[0]), 128'(k == 4 || k == 10));
      chk($sformatf("b2b_rdy0_k%0d", k), 128'(rdy[0]), 128'(k == 5));
      chk($sformatf("b2b_busy0_k%0d", k), 128'(bsy[0]), 128'(k != 5));
      if (k == 4 || k == 10)
        chk($sformatf("b2b_os0_k%0d", k), os[0], {4{32'h4d7ebdf8}});
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    out_ready = 1'b0;
    idle_all("b2b_drain");

`ifdef AES_INV_MIXCOL_EN
    in_inv = 1'b1;
    run_all("inv8e", {4{32'h8e4da1bc}}, {4{32'hdb135345}}, 1'b0);
    in_inv = 1'b0;
    run_all("rt_fwd", {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5},
            {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6}, 1'b0);
    in_inv = 1'b1;
    run_all("rt_inv", {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6},
            {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, 1'b0);
    in_inv = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_mixcol_seq.md
AES_MIXCOL_SEQ -- requirements
Module: aes_mixcol_seq

Interface
REQ-001 SHALL have parameter NUM_COL_UNITS, default 1: number of columns transformed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  input state offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port in_state  input  128  AES state; column c = bits [127-32c -: 32]; row 0 is the column's MSB byte.
REQ-007 SHALL have port in_inv  input  1  select InvMixColumns; present only when AES_INV_MIXCOL_EN is defined.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_state  output  128  transformed state, same byte mapping as in_state.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; no input accepted in CALC or DONE.
REQ-014 An acceptance is in_valid && in_ready at a rising edge: capture in_state (and in_inv) into the working register, clear the column counter, go to CALC.
REQ-015 In CALC each cycle SHALL transform NUM_COL_UNITS consecutive columns, starting at column 0, writing results back in place.
REQ-016 The column counter SHALL advance by NUM_COL_UNITS per cycle; after the cycle processing column 3, FSM goes to DONE.
REQ-017 Latency: out_valid SHALL rise exactly 4/NUM_COL_UNITS cycles after the acceptance edge (N=1: 4, N=2: 2, N=4: 1).
REQ-018 Forward column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, all in GF(2^8) with polynomial 0x11B; multiply-by-2 is xtime (shift left, XOR 0x1B when MSB was set), 3x = 2x ^ x.
REQ-019 In DONE, out_valid SHALL be 1 and out_state SHALL hold stable until out_ready is sampled high; then go to IDLE and drop out_valid the next cycle.
REQ-020 DONE with out_ready held low SHALL stall indefinitely without corrupting out_state.
REQ-021 out_state SHALL be driven from the working register. Its value outside DONE is don't-care for consumers but SHALL not be X after reset.
REQ-022 in_valid in CALC/DONE SHALL be ignored. The upstream source holds its data until in_ready rises.
REQ-023 Back-to-back: a new acceptance SHALL be possible on the cycle after the DONE→IDLE handoff. Minimum period is 4/N + 2 cycles.

Reset
REQ-024 rst high SHALL asynchronously force FSM=IDLE, column counter=0, working register=0, captured inv=0.
REQ-025 Outputs SHALL be in_ready=1 after reset release, out_valid=0, busy=0, out_state=128'h0.
REQ-026 rst mid-CALC or in DONE SHALL abort the operation; the partial result SHALL never appear with out_valid=1.

Configuration
REQ-027 Macro AES_INV_MIXCOL_EN. When defined: in_inv port exists. A captured inv=1 applies InvMixColumns coefficients {0e,0b,0d,09} in circulant order via chained xtime (x2, x4, x8). Latency is identical to forward mode.
REQ-028 Without AES_INV_MIXCOL_EN: no in_inv port, forward transform only, no inverse logic synthesized.

Structure
REQ-029 Package aes_pkg SHALL hold: FSM state enum, AES_POLY_LOW = 8'h1B, column width 32, column count 4.
REQ-030 Sub-module aes_mixcol_column SHALL be the combinational one-column transform. It is built from aes_xtime instances and instantiated NUM_COL_UNITS times. The FSM, counter, handshake and working register stay in aes_mixcol_seq.

Verification
REQ-031 Column db135345 in all four columns, N=1 -> out_state = 4x 8e4da1bc, out_valid exactly 4 cycles after acceptance.
REQ-032 State {f20a225c, 01010101, c6c6c6c6, d4d4d4d5} with N=1,2,4 -> {9fdc589d, 01010101, c6c6c6c6, d5d5d7d6}; latency 4/2/1.
REQ-033 Result ready with out_ready low for 10 cycles -> out_valid and out_state stable throughout; in_ready=0 and in_valid ignored.
REQ-034 rst pulse 2 cycles after acceptance -> out_valid never asserts, out_state=0, in_ready=1 after release. Next input 2d26314c x4 -> 4d7ebdf8 x4.
REQ-035 With AES_INV_MIXCOL_EN, in_inv=1, column 8e4da1bc x4 -> db135345 x4. Back-to-back forward then inverse of the same data round-trips to the original input.
